// File: rtl/lsm_pkg.sv
// lsm_pkg: state encoding, phase codes and default sizes shared by the LSM scheduler.
package lsm_pkg;
  localparam int LSM_DAY = 8;
  localparam int LSM_N = 256;
  typedef enum logic [3:0] {
    IDLE, INIT, ACC_ISSUE, ACC_STREAM, WAIT_ACC, INV_ISSUE, WAIT_INV, UPD_STREAM, AVG_STREAM, DONE
  } state_e;
  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_INIT = 3'd1;
  localparam logic [2:0] PH_ACC = 3'd2;
  localparam logic [2:0] PH_UPD = 3'd3;
  localparam logic [2:0] PH_AVG = 3'd4;
  localparam logic [2:0] PH_WAIT = 3'd5;
  // DONE shares the catch-all issue/wait code
  function automatic logic [2:0] phase_of(input state_e s);
    return s == IDLE ? PH_IDLE : s == INIT ? PH_INIT : s == ACC_STREAM ? PH_ACC :
           s == UPD_STREAM ? PH_UPD : s == AVG_STREAM ? PH_AVG : PH_WAIT;
  endfunction
endpackage

// File: rtl/lsm_stream_counter.sv
// lsm_stream_counter: power-of-2 path-index counter that advances on en && ready and wraps after N-1.
module lsm_stream_counter #(
  parameter int N = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ready,
  output logic [$clog2(N)-1:0] idx,
  output logic                 last,
  output logic                 wrap
);
  logic [$clog2(N)-1:0] idx_q, idx_d;
  always_comb begin
    idx_d = en && ready ? idx_q + 1'b1 : idx_q;
    last = idx_q == '1;
    wrap = en && ready && last;
    idx = idx_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx_q <= '0;
    else idx_q <= idx_d;
endmodule

// File: rtl/lsm_scheduler.sv
// lsm_scheduler: Longstaff-Schwartz backward-induction sequencer (days, index streams, accumulator/inverter handshakes).
// Optional wait-state watchdog enabled by defining LSM_SCHED_WATCHDOG_EN.
module lsm_scheduler
  import lsm_pkg::*;
#(
  parameter int DAY = LSM_DAY,
  parameter int N = LSM_N,
  parameter int WD_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stream_ready,
  input  logic                   xtx_valid,
  input  logic                   xty_valid,
  input  logic                   inv_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             phase,
  output logic [$clog2(DAY)-1:0] day,
  output logic [$clog2(N)-1:0]   idx,
  output logic                   idx_valid,
  output logic                   idx_last,
  output logic                   acc_start,
  output logic                   inv_start
);
  localparam int DW = $clog2(DAY);
  if (DAY < 3 || N < 4 || (N & (N - 1)) != 0 || WD_CYCLES < 1) begin : g_bad_cfg
    $error("lsm_scheduler: unsupported DAY/N/WD_CYCLES");
  end
  state_e state_q, state_d;
  logic [DW-1:0] day_q, day_d;
  logic xtx_flag_q, xtx_flag_d, xty_flag_q, xty_flag_d;
  logic last, wrap, acc_ok, timeout;
  lsm_stream_counter #(.N(N)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(idx_valid), .ready(stream_ready), .idx(idx), .last(last), .wrap(wrap)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      day_q <= '0;
      xtx_flag_q <= 1'b0;
      xty_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      day_q <= day_d;
      xtx_flag_q <= xtx_flag_d;
      xty_flag_q <= xty_flag_d;
    end
  // Completion strobes may arrive early as pulses; flags hold them, but only after the issue cycle
  assign acc_ok = (xtx_flag_q | xtx_valid) & (xty_flag_q | xty_valid);
  always_comb begin
    state_d = state_q;
    day_d = day_q;
    xtx_flag_d = state_q != ACC_ISSUE && (xtx_flag_q || xtx_valid);
    xty_flag_d = state_q != ACC_ISSUE && (xty_flag_q || xty_valid);
    case (state_q)
      IDLE: if (start) begin
        state_d = INIT;
        day_d = DW'(DAY - 1);
      end
      INIT: if (wrap) begin
        state_d = ACC_ISSUE;
        day_d = DW'(DAY - 2);
      end
      ACC_ISSUE: state_d = ACC_STREAM;
      ACC_STREAM: state_d = wrap ? WAIT_ACC : ACC_STREAM;
      WAIT_ACC: state_d = acc_ok ? INV_ISSUE : timeout ? IDLE : WAIT_ACC;
      INV_ISSUE: state_d = WAIT_INV;
      WAIT_INV: state_d = inv_valid ? UPD_STREAM : timeout ? IDLE : WAIT_INV;
      UPD_STREAM: if (wrap) begin
        state_d = day_q == DW'(1) ? AVG_STREAM : ACC_ISSUE;
        day_d = day_q == DW'(1) ? day_q : day_q - 1'b1;
      end
      AVG_STREAM: state_d = wrap ? DONE : AVG_STREAM;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    phase = phase_of(state_q);
    day = day_q;
    idx_valid = state_q inside {INIT, ACC_STREAM, UPD_STREAM, AVG_STREAM};
    idx_last = idx_valid && last;
    acc_start = state_q == ACC_ISSUE;
    inv_start = state_q == INV_ISSUE;
  end
`ifdef LSM_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic err_q, err_d;
  assign timeout = (state_q == WAIT_ACC || state_q == WAIT_INV) && wd_q == WW'(WD_CYCLES - 1);
  always_comb begin
    wd_d = (state_q == WAIT_ACC || state_q == WAIT_INV) && state_d == state_q ? wd_q + 1'b1 : '0;
    err_d = state_q == IDLE && start ? 1'b0 : err_q | timeout;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_q <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      err_q <= err_d;
    end
  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lsm_scheduler.sv
// tb_lsm_scheduler: directed checks on a DAY=3/N=4 instance plus a default-size instance for the long run.
module tb_lsm_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stream_ready = 1'b1;
  logic xtx_valid = 1'b0, xty_valid = 1'b0, inv_valid = 1'b0, start_b = 1'b0;
  logic busy, done, err, idx_valid, idx_last, acc_start, inv_start;
  logic [2:0] phase;
  logic [1:0] day, idx;
  logic busy_b, done_b, err_b, idx_valid_b, idx_last_b, acc_start_b, inv_start_b;
  logic [2:0] phase_b, day_b;
  logic [7:0] idx_b;
  int errors = 0, checks = 0, cyc = 0, e0 = 1 << 30, e0b = 1 << 30;
  int done_cnt, done_k, acc_cnt, acc_k, acc_day, inv_cnt, inv_k, err_k;
  int stalls, beats, exp_idx, seq_bad, last_bad, snap_at;
  logic [13:0] snap;
  int done_b_cnt, done_bk, acc_b, inv_b, nd, dbad, prev_b;
  localparam logic [13:0] SNAP_INIT = {1'b1, 1'b0, 1'b0, 3'd1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [13:0] SNAP_WAIT = {1'b1, 1'b0, 1'b0, 3'd5, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  lsm_scheduler #(.DAY(3), .N(4), .WD_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stream_ready(stream_ready),
    .xtx_valid(xtx_valid), .xty_valid(xty_valid), .inv_valid(inv_valid),
    .busy(busy), .done(done), .err(err), .phase(phase), .day(day), .idx(idx),
    .idx_valid(idx_valid), .idx_last(idx_last), .acc_start(acc_start), .inv_start(inv_start)
  );
  lsm_scheduler dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stream_ready(1'b1),
    .xtx_valid(1'b1), .xty_valid(1'b1), .inv_valid(1'b1),
    .busy(busy_b), .done(done_b), .err(err_b), .phase(phase_b), .day(day_b), .idx(idx_b),
    .idx_valid(idx_valid_b), .idx_last(idx_last_b), .acc_start(acc_start_b), .inv_start(inv_start_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] outs();
    return {busy, done, err, phase, day, idx, idx_valid, idx_last, acc_start, inv_start};
  endfunction
  function automatic logic [18:0] outs_b();
    return {busy_b, done_b, err_b, phase_b, idx_b, idx_valid_b, idx_last_b, acc_start_b, inv_start_b};
  endfunction

  always @(negedge clk) begin
    if (done) begin done_cnt++; done_k = cyc - e0; end
    if (acc_start) begin acc_cnt++; acc_k = cyc - e0; acc_day = int'(day); end
    if (inv_start) begin inv_cnt++; inv_k = cyc - e0; end
    if (err && err_k < 0) err_k = cyc - e0;
    if (cyc - e0 == snap_at) snap = outs();
    if (idx_valid && !stream_ready) stalls++;
    if (idx_valid && stream_ready) begin
      if (int'(idx) != exp_idx) seq_bad++;
      exp_idx = (exp_idx + 1) % 4;
      beats++;
    end
    if (idx_last !== (idx_valid && idx == 2'd3)) last_bad++;
  end

  always @(negedge clk) begin
    if (done_b) begin done_b_cnt++; done_bk = cyc - e0b; end
    if (acc_start_b) acc_b++;
    if (inv_start_b) inv_b++;
    if (busy_b && int'(day_b) != prev_b) begin
      if (int'(day_b) != 7 - nd) dbad++;
      nd++;
      prev_b = int'(day_b);
    end
  end

  task automatic clear_stats();
    e0 = 1 << 30;
    done_cnt = 0; done_k = -1; acc_cnt = 0; acc_k = -1; acc_day = -1; inv_cnt = 0; inv_k = -1; err_k = -1;
    stalls = 0; beats = 0; exp_idx = 0; seq_bad = 0; last_bad = 0; snap = '0;
  endtask

  task automatic run(input logic [63:0] xm, input logic [63:0] ym, input bit tog, input int sk,
                     input bit iv, input int lim);
    int k;
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1; e0 = cyc + 1; inv_valid = iv; xtx_valid = 1'b0; xty_valid = 1'b0; stream_ready = 1'b1;
    for (int t = 0; t < lim && done_cnt == 0; t++) begin
      @(posedge clk); #1;
      k = cyc - e0;
      start = k == sk;
      xtx_valid = xm[6'(k > 63 ? 63 : k)];
      xty_valid = ym[6'(k > 63 ? 63 : k)];
      stream_ready = tog ? !stream_ready : 1'b1;
    end
    start = 1'b0; stream_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %b want 0", outs()); end
    checks++; if (outs_b() !== '0 || day_b !== '0) begin errors++; $display("FAIL reset_outputs_big: got %b/%0d want 0", outs_b(), day_b); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    snap_at = 0;
    run('1, '1, 1'b0, -9, 1'b1, 40);
    checks++; if (snap !== SNAP_INIT) begin errors++; $display("FAIL basic_init_outs: got %b want %b", snap, SNAP_INIT); end
    checks++; if (done_k !== 20) begin errors++; $display("FAIL basic_done_edge: got %0d want 20", done_k); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (acc_cnt !== 1 || acc_k !== 4) begin errors++; $display("FAIL basic_acc_start: got %0d@%0d want 1@4", acc_cnt, acc_k); end
    checks++; if (acc_day !== 1) begin errors++; $display("FAIL basic_acc_day: got %0d want 1", acc_day); end
    checks++; if (inv_cnt !== 1 || inv_k !== 10) begin errors++; $display("FAIL basic_inv_start: got %0d@%0d want 1@10", inv_cnt, inv_k); end
    checks++; if (beats !== 16 || seq_bad !== 0) begin errors++; $display("FAIL basic_beats: got %0d beats %0d bad want 16/0", beats, seq_bad); end
    checks++; if (last_bad !== 0) begin errors++; $display("FAIL basic_idx_last: got %0d bad want 0", last_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_stall();
    snap_at = -9;
    run('1, '1, 1'b1, -9, 1'b1, 80);
    checks++; if (stalls < 1) begin errors++; $display("FAIL stall_seen: got %0d want >0", stalls); end
    checks++; if (done_k !== 20 + stalls) begin errors++; $display("FAIL stall_done_edge: got %0d want %0d", done_k, 20 + stalls); end
    checks++; if (beats !== 16 || seq_bad !== 0) begin errors++; $display("FAIL stall_beats: got %0d beats %0d bad want 16/0", beats, seq_bad); end
    checks++; if (last_bad !== 0) begin errors++; $display("FAIL stall_idx_last: got %0d bad want 0", last_bad); end
  endtask

  task automatic test_wait_order();
    snap_at = 12;
    run(64'd1 << 13, 64'd1 << 6, 1'b0, -9, 1'b1, 40);
    checks++; if (snap !== SNAP_WAIT) begin errors++; $display("FAIL order_wait_outs: got %b want %b", snap, SNAP_WAIT); end
    checks++; if (inv_cnt !== 1 || inv_k !== 14) begin errors++; $display("FAIL order_inv_start: got %0d@%0d want 1@14", inv_cnt, inv_k); end
    checks++; if (done_k !== 24) begin errors++; $display("FAIL order_done_edge: got %0d want 24", done_k); end
    snap_at = -9;
    run(64'd1 << 9, 64'd1 << 9, 1'b0, -9, 1'b1, 40);
    checks++; if (inv_k !== 10 || done_k !== 20) begin errors++; $display("FAIL simul_timing: got inv@%0d done@%0d want 10/20", inv_k, done_k); end
    run((64'd1 << 3) | (64'd1 << 4) | (64'd1 << 11), (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 11), 1'b0, -9, 1'b1, 40);
    checks++; if (inv_k !== 12 || done_k !== 22) begin errors++; $display("FAIL issue_ignore: got inv@%0d done@%0d want 12/22", inv_k, done_k); end
  endtask

  task automatic test_start_busy();
    snap_at = -9;
    run('1, '1, 1'b0, 12, 1'b1, 40);
    checks++; if (done_k !== 20 || done_cnt !== 1 || acc_cnt !== 1) begin errors++; $display("FAIL busy_start: got done@%0d x%0d acc %0d want 20 x1 acc 1", done_k, done_cnt, acc_cnt); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    snap_at = -9;
    run('1, '1, 1'b0, -9, 1'b1, 7);
    checks++; if (phase !== 3'd2 || idx_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_phase: got %0d/%b want 2/1", phase, idx_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs() !== '0) begin errors++; $display("FAIL mid_async_reset: got %b want 0", outs()); end
    @(posedge clk); #1 rst_n = 1'b1;
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
    run('1, '1, 1'b0, -9, 1'b1, 40);
    checks++; if (done_k !== 20 || acc_cnt !== 1 || beats !== 16) begin errors++; $display("FAIL mid_rerun: got done@%0d acc %0d beats %0d want 20/1/16", done_k, acc_cnt, beats); end
  endtask

  task automatic test_watchdog();
    snap_at = -9;
    run('1, '1, 1'b0, -9, 1'b0, 40);
`ifdef LSM_SCHED_WATCHDOG_EN
    checks++; if (err_k !== 27) begin errors++; $display("FAIL wd_err_edge: got %0d want 27", err_k); end
    checks++; if (err !== 1'b1 || busy !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL wd_idle: got err=%b busy=%b phase=%0d want 1/0/0", err, busy, phase); end
    checks++; if (done_cnt !== 0 || inv_cnt !== 1) begin errors++; $display("FAIL wd_no_done: got done %0d inv %0d want 0/1", done_cnt, inv_cnt); end
    snap_at = 0;
    run('1, '1, 1'b0, -9, 1'b1, 40);
    checks++; if (snap !== SNAP_INIT || done_k !== 20) begin errors++; $display("FAIL wd_restart: got %b done@%0d want %b/20", snap, done_k, SNAP_INIT); end
`else
    checks++; if (busy !== 1'b1 || phase !== 3'd5 || err !== 1'b0) begin errors++; $display("FAIL wait_forever: got busy=%b phase=%0d err=%b want 1/5/0", busy, phase, err); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL wait_no_done: got %0d want 0", done_cnt); end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
`endif
  endtask

  task automatic test_defaults();
    done_b_cnt = 0; done_bk = -1; acc_b = 0; inv_b = 0; nd = 0; dbad = 0; prev_b = -1;
    @(posedge clk); #1 start_b = 1'b1; e0b = cyc + 1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int t = 0; t < 4000 && done_b_cnt == 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done_bk !== 3608 || done_b_cnt !== 1) begin errors++; $display("FAIL big_done_edge: got %0d x%0d want 3608 x1", done_bk, done_b_cnt); end
    checks++; if (acc_b !== 6 || inv_b !== 6) begin errors++; $display("FAIL big_issue_counts: got acc %0d inv %0d want 6/6", acc_b, inv_b); end
    checks++; if (nd !== 7 || dbad !== 0) begin errors++; $display("FAIL big_day_seq: got %0d days %0d bad want 7/0", nd, dbad); end
    checks++; if (outs_b() !== '0) begin errors++; $display("FAIL big_idle_after: got %b want 0", outs_b()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wait_order();
    test_start_busy();
    test_reset_mid();
    test_watchdog();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsm_scheduler.md
# lsm_scheduler

Control-only sequencer for the Monte-Carlo option-pricing core's Longstaff–Schwartz backward induction. It steps the exercise day from the last day down to day 1 and drives the path-index streams the datapath needs at each day. It issues start pulses to the XTX/XTY accumulators and the 3×3 matrix inverter, and waits on their valid strobes. It signals completion once the cash-flow average pass has streamed. It carries no arithmetic data; all path, payoff and cash-flow storage stays in the datapath.

## Interface
- DAY, 8, number of exercise days (≥3)
- N, 256, paths per day (power of 2, ≥4)
- WD_CYCLES, 4096, watchdog limit in cycles (used only with the watchdog macro)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a pricing run; sampled only in IDLE
- stream_ready  in  1  datapath accepts current index beat
- xtx_valid  in  1  XTX accumulation complete (pulse or level)
- xty_valid  in  1  XTY accumulation complete (pulse or level)
- inv_valid  in  1  matrix inverse complete
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- err  out  1  watchdog expiry flag, sticky until next accepted start
- phase  out  3  0 IDLE, 1 INIT, 2 ACC, 3 UPD, 4 AVG, 5 WAIT/ISSUE
- day  out  clog2(DAY)  current exercise day
- idx  out  clog2(N)  path index of current beat
- idx_valid  out  1  idx is a live beat
- idx_last  out  1  idx_valid && idx==N-1
- acc_start  out  1  one-cycle pulse to XTX/XTY
- inv_start  out  1  one-cycle pulse to MAT_INV

## Operation
- States: IDLE, INIT, ACC_ISSUE, ACC_STREAM, WAIT_ACC, INV_ISSUE, WAIT_INV, UPD_STREAM, AVG_STREAM, DONE.
- IDLE → INIT on start; day=DAY-1, idx=0, err cleared.
- Stream states (INIT, ACC_STREAM, UPD_STREAM, AVG_STREAM): idx_valid=1. idx advances only on idx_valid&&stream_ready. The accepted beat with idx==N-1 wraps idx to 0 and exits the state.
- INIT → ACC_ISSUE with day=DAY-2.
- ACC_ISSUE (1 cycle): acc_start=1; clear sticky xtx/xty flags. Valids seen in this cycle are ignored. → ACC_STREAM.
- Flags set on any xtx_valid/xty_valid from the cycle after ACC_ISSUE onward.
- WAIT_ACC exits when (xtx_flag|xtx_valid)&(xty_flag|xty_valid), in either order or simultaneously. → INV_ISSUE.
- INV_ISSUE (1 cycle): inv_start=1 → WAIT_INV. WAIT_INV exits on inv_valid. → UPD_STREAM.
- After UPD_STREAM: if day==1 → AVG_STREAM; else day decrements → ACC_ISSUE.
- AVG_STREAM → DONE (done=1, 1 cycle) → IDLE.
- start while busy is ignored. Reset mid-run returns to IDLE immediately, with no done pulse.
- All outputs are registered/decoded from state. Reset values: busy=0, done=0, err=0, phase=0, day=0, idx=0, idx_valid=0, idx_last=0, acc_start=0, inv_start=0.

## Timing
- The edge sampling start is E0; INIT occupies cycles after E0–E(N-1).
- With stream_ready tied 1 and all valids tied 1, each regression day costs 2N+4 cycles.
- Under those conditions done rises at edge 2N+(DAY-2)(2N+4) after E0. For defaults that is edge 3608.
- stream_ready low stalls a stream state indefinitely with idx and idx_valid held.
- Each ISSUE state and each WAIT state is at least 1 cycle.

## Configuration
- LSM_SCHED_WATCHDOG_EN defined: a counter runs in WAIT_ACC and WAIT_INV and clears on state entry.
  - Reaching WD_CYCLES sets err=1 and goes to IDLE without done.
- LSM_SCHED_WATCHDOG_EN undefined: err is tied 0 and the wait states wait indefinitely.

## Structure
- lsm_pkg holds the state enum, phase encodings, and the default DAY/N constants.
- Sub-module lsm_stream_counter: N-deep index counter with ready handshake, last flag and wrap. It is shared by all four stream states.

## Test plan
- DAY=3, N=4, stream_ready=1, valids held 1, start pulse → done at edge 20; one acc_start at edge 4; one inv_start at edge 10; idx beats 0..3 in four stream phases.
- Same config, stream_ready toggling 1/0 → idx never skips or repeats; done delayed exactly by the count of low-ready cycles in stream states.
- xty_valid pulses during ACC_STREAM and xtx_valid 5 cycles into WAIT_ACC → INV_ISSUE on the cycle after xtx_valid; same run with both valids simultaneous → exits after 1 cycle.
- start asserted during UPD_STREAM → ignored; rst_n low mid-ACC_STREAM → all outputs at reset values asynchronously; a fresh start after release runs the full sequence.
- Defaults (DAY=8, N=256) → day sequence 7,6,5,4,3,2,1; six acc_start pulses; done at edge 3608.
- With LSM_SCHED_WATCHDOG_EN and WD_CYCLES=16, inv_valid never asserted → err=1 after 16 WAIT_INV cycles, state IDLE, no done; next start clears err.
